// File: rtl/divider_arbiter.sv
// divider_arbiter: NREQ requesters share one 4-bit unsigned divider.
// A single-entry result stage holds one quotient/remainder pair; a new
// request is granted only when that stage is empty or being drained.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   req_valid[NREQ]  per-requester request valid
//   req_ready[NREQ]  per-requester grant (combinational, one-hot or zero)
//   req_a, req_b     dividend / divisor, nibble i belongs to requester i
//   rsp_valid        result valid
//   rsp_ready        result consumer ready
//   rsp_id           requester that owns the result
//   rsp_q, rsp_r     quotient / remainder
//   rsp_dz           divide-by-zero flag
//   dz_cnt           saturating count of accepted divide-by-zero requests
//
// Configuration
//   DIVARB_ROUND_ROBIN_EN  defined: round-robin arbitration starting after
//                          the last granted index; undefined: fixed
//                          priority, lowest valid index wins.
module divider_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [3:0]        rsp_q,
    output logic [3:0]        rsp_r,
    output logic              rsp_dz,
    output logic [7:0]        dz_cnt
);

    localparam int unsigned DW     = 4;
    localparam int unsigned CNTW   = 8;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic              rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q,    rsp_id_d;
    logic [DW-1:0]     rsp_q_q,     rsp_q_d;
    logic [DW-1:0]     rsp_r_q,     rsp_r_d;
    logic              rsp_dz_q,    rsp_dz_d;
    logic [CNTW-1:0]   dz_cnt_q,    dz_cnt_d;

    logic              stage_free_c;
    logic              gnt_any_c;
    logic [IDW-1:0]    gnt_idx_c;
    logic              xfer_c;
    logic [DW-1:0]     sel_a_c;
    logic [DW-1:0]     sel_b_c;
    logic [DW-1:0]     div_q_c;
    logic [DW-1:0]     div_r_c;
    logic              div_dz_c;
    logic [DW:0]       rem_c;
    logic [DW-1:0]     quo_c;

    assign stage_free_c = !rsp_valid_q || rsp_ready;

`ifdef DIVARB_ROUND_ROBIN_EN
    logic [IDW-1:0] ptr_q, ptr_d;

    // Round-robin search beginning one past the last granted requester.
    always_comb begin
        int unsigned idx;
        gnt_any_c = 1'b0;
        gnt_idx_c = '0;
        idx       = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (!gnt_any_c && req_valid[idx]) begin
                gnt_any_c = 1'b1;
                gnt_idx_c = IDW'(idx);
            end
        end
    end
`else
    // Fixed priority: lowest valid index wins.
    always_comb begin
        gnt_any_c = 1'b0;
        gnt_idx_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!gnt_any_c && req_valid[i]) begin
                gnt_any_c = 1'b1;
                gnt_idx_c = IDW'(i);
            end
        end
    end
`endif

    // Grant is gated by reset so no requester sees ready while held in reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && stage_free_c && gnt_any_c) begin
            req_ready[gnt_idx_c] = 1'b1;
        end
    end

    assign xfer_c = |(req_valid & req_ready);

    // Operand mux for the winning requester.
    assign sel_a_c = req_a[32'(gnt_idx_c)*DW +: DW];
    assign sel_b_c = req_b[32'(gnt_idx_c)*DW +: DW];

    // Restoring division; the partial remainder stays below the divisor,
    // so one extra bit suffices for the trial subtraction.
    always_comb begin
        rem_c = '0;
        quo_c = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            rem_c = {rem_c[DW-1:0], sel_a_c[i]};
            if (rem_c >= {1'b0, sel_b_c}) begin
                rem_c    = rem_c - {1'b0, sel_b_c};
                quo_c[i] = 1'b1;
            end
        end
    end

    // Divide by zero reports zero quotient and remainder.
    always_comb begin
        div_dz_c = (sel_b_c == '0);
        div_q_c  = div_dz_c ? '0 : quo_c;
        div_r_c  = div_dz_c ? '0 : rem_c[DW-1:0];
    end

    // Result stage next state: load on transfer, clear when drained.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_q_d     = rsp_q_q;
        rsp_r_d     = rsp_r_q;
        rsp_dz_d    = rsp_dz_q;
        dz_cnt_d    = dz_cnt_q;
        if (xfer_c) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gnt_idx_c;
            rsp_q_d     = div_q_c;
            rsp_r_d     = div_r_c;
            rsp_dz_d    = div_dz_c;
            if (div_dz_c && (dz_cnt_q != CNT_MAX)) begin
                dz_cnt_d = dz_cnt_q + CNTW'(1);
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

`ifdef DIVARB_ROUND_ROBIN_EN
    // Pointer advances only on an actual transfer.
    always_comb begin
        ptr_d = ptr_q;
        if (xfer_c) begin
            ptr_d = gnt_idx_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDW'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q_q     <= '0;
            rsp_r_q     <= '0;
            rsp_dz_q    <= 1'b0;
            dz_cnt_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_q_q     <= rsp_q_d;
            rsp_r_q     <= rsp_r_d;
            rsp_dz_q    <= rsp_dz_d;
            dz_cnt_q    <= dz_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_q     = rsp_q_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_dz    = rsp_dz_q;
    assign dz_cnt    = dz_cnt_q;

endmodule
